// File: rtl/mips_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_fetch_unit_pkg;

    localparam int unsigned MIPS_PC_WIDTH    = 32;
    localparam int unsigned MIPS_INSTR_WIDTH = 32;
    localparam int unsigned FETCH_DEPTH_DEF  = 4;
    localparam int unsigned PC_STEP          = 4;

    typedef logic [MIPS_PC_WIDTH-1:0]    pc_t;
    typedef logic [MIPS_INSTR_WIDTH-1:0] instr_t;

    // One prefetch slot: the PC it was fetched from, the returned word and
    // whether memory has answered yet.
    typedef struct packed {
        pc_t    pc;
        instr_t instr;
        logic   filled;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, decode handshake and
// redirect. The fetch unit uses the master view, its environment the slave view.
interface mips_fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   if_valid;
    logic                   if_ready;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]    if_pc;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   fetch_misalign_exc;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, fetch_misalign_exc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, fetch_misalign_exc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/mips_fetch_unit_queue.sv
// Prefetch queue: circular buffer of fetch entries. Entries are allocated at
// issue (tail), filled in order as responses return (fill pointer) and popped
// by decode (head). Pointers carry a wrap bit so full/empty are unambiguous.
module mips_fetch_queue
    import mips_fetch_unit_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = FETCH_DEPTH_DEF,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_alloc,
    input  pc_t              i_alloc_pc,
    input  logic             i_fill,
    input  instr_t           i_fill_instr,
    input  logic             i_pop,
    input  logic             i_flush,
    output pc_t              o_head_pc,
    output instr_t           o_head_instr,
    output logic             o_head_valid,
    output logic [CNT_W-1:0] o_alloc_cnt,
    output logic [CNT_W-1:0] o_unfilled_cnt
);

    fetch_entry_t     r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_tail;
    logic [PTR_W:0]   r_fill;

    logic [PTR_W-1:0] w_head_idx;
    logic [PTR_W-1:0] w_tail_idx;
    logic [PTR_W-1:0] w_fill_idx;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];
    assign w_fill_idx = r_fill[PTR_W-1:0];

    // Storage and pointer update; flush frees everything, stale filled bits
    // are harmless because a slot is cleared again when it is reallocated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
        end else begin
            if (i_alloc) begin
                r_mem[w_tail_idx].pc     <= i_alloc_pc;
                r_mem[w_tail_idx].instr  <= '0;
                r_mem[w_tail_idx].filled <= 1'b0;
                r_tail                   <= r_tail + (PTR_W+1)'(1);
            end
            if (i_fill) begin
                r_mem[w_fill_idx].instr  <= i_fill_instr;
                r_mem[w_fill_idx].filled <= 1'b1;
                r_fill                   <= r_fill + (PTR_W+1)'(1);
            end
            if (i_pop) begin
                r_head <= r_head + (PTR_W+1)'(1);
            end
        end
    end

    assign o_head_pc      = r_mem[w_head_idx].pc;
    assign o_head_instr   = r_mem[w_head_idx].instr;
    assign o_head_valid   = (r_head != r_tail) && r_mem[w_head_idx].filled;
    assign o_alloc_cnt    = r_tail - r_head;
    assign o_unfilled_cnt = r_tail - r_fill;

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled instruction-fetch stage: PC register, request issue gating,
// discard counter for responses orphaned by a redirect, and redirect handling.
// Optional build macro MIPS_FETCH_ALIGN_CHK_EN: a misaligned redirect target
// raises fetch_misalign_exc for one cycle and freezes fetch until the next
// aligned redirect. Without it the target's low two bits are cleared.
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = MIPS_PC_WIDTH,
    parameter int unsigned         INSTR_WIDTH = MIPS_INSTR_WIDTH,
    parameter int unsigned         FIFO_DEPTH  = FETCH_DEPTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic               clk,
    input logic               rst_n,
    mips_fetch_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PC_WIDTH-1:0]    r_pc;
    logic [CNT_W-1:0]       r_discard_cnt;
    logic                   r_frozen;

    logic [CNT_W-1:0]       w_alloc_cnt;
    logic [CNT_W-1:0]       w_unfilled_cnt;
    logic [CNT_W:0]         w_occupancy;
    logic                   w_has_room;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_discarding;
    logic                   w_rsp_legal;
    logic                   w_fill;
    logic                   w_head_valid;
    logic                   w_if_valid;
    logic                   w_pop;
    logic [PC_WIDTH-1:0]    w_target;
    logic [PC_WIDTH-1:0]    w_head_pc;
    logic [INSTR_WIDTH-1:0] w_head_instr;
    logic [INSTR_WIDTH-1:0] w_rsp_data;

    // Outstanding entries plus responses still owed from before a redirect
    // both hold a slot, so together they bound the in-flight requests.
    assign w_occupancy = {1'b0, w_alloc_cnt} + {1'b0, r_discard_cnt};
    assign w_has_room  = w_occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign w_issue     = rst_n && !bus.redirect_valid && !r_frozen && w_has_room;
    assign w_accept    = w_issue && bus.imem_req_ready;

    assign w_discarding = (r_discard_cnt != '0);
    assign w_rsp_legal  = bus.imem_rsp_valid && (w_discarding || (w_unfilled_cnt != '0));
    assign w_fill       = bus.imem_rsp_valid && !w_discarding && (w_unfilled_cnt != '0)
                          && !bus.redirect_valid;
    assign w_rsp_data   = bus.imem_rsp_data;

    assign w_if_valid = w_head_valid && !bus.redirect_valid;
    assign w_pop      = w_if_valid && bus.if_ready;

    assign bus.imem_req_valid = w_issue;
    assign bus.imem_addr      = r_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_instr       = w_head_instr;
    assign bus.if_pc          = w_head_pc;

`ifdef MIPS_FETCH_ALIGN_CHK_EN
    logic r_misalign;
    logic w_misaligned;

    assign w_misaligned           = (bus.redirect_pc[1:0] != 2'b00);
    assign w_target               = bus.redirect_pc;
    assign bus.fetch_misalign_exc = r_misalign;

    // Misalign pulse for the cycle after the redirect; freeze until an aligned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
            r_frozen   <= 1'b0;
        end else begin
            r_misalign <= bus.redirect_valid && w_misaligned;
            if (bus.redirect_valid) begin
                r_frozen <= w_misaligned;
            end
        end
    end
`else
    assign w_target               = bus.redirect_pc & ~PC_WIDTH'(3);
    assign bus.fetch_misalign_exc = 1'b0;
    assign r_frozen               = 1'b0;
`endif

    // Program counter: redirect wins, otherwise step on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc <= w_target;
        end else if (w_accept) begin
            r_pc <= r_pc + PC_WIDTH'(PC_STEP);
        end
    end

    // Discard counter: a redirect turns every unfilled entry into a response
    // to drop; a response arriving in that same cycle already belongs to the
    // old set, so it is netted off here instead of being counted and dropped later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_discard_cnt <= '0;
        end else if (bus.redirect_valid) begin
            r_discard_cnt <= r_discard_cnt + w_unfilled_cnt - CNT_W'(w_rsp_legal);
        end else if (bus.imem_rsp_valid && w_discarding) begin
            r_discard_cnt <= r_discard_cnt - CNT_W'(1);
        end
    end

    a_rsp_legal: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (w_discarding || (w_unfilled_cnt != '0)));

    mips_fetch_queue #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_alloc        (w_accept),
        .i_alloc_pc     (r_pc),
        .i_fill         (w_fill),
        .i_fill_instr   (w_rsp_data),
        .i_pop          (w_pop),
        .i_flush        (bus.redirect_valid),
        .o_head_pc      (w_head_pc),
        .o_head_instr   (w_head_instr),
        .o_head_valid   (w_head_valid),
        .o_alloc_cnt    (w_alloc_cnt),
        .o_unfilled_cnt (w_unfilled_cnt)
    );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomised bench for mips_fetch_unit with an in-order memory model and a
// scoreboard of expected fetch entries.
module tb_mips_fetch_unit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    mips_fetch_unit #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .FIFO_DEPTH  (DEPTH),
        .RESET_PC    (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [31:0] pc; bit filled; } exp_t;
    typedef struct { int epoch; int due; logic [31:0] addr; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          pops = 0;
    int          ready_pct = 100;
    int          lat_extra = 0;
    logic [31:0] model_pc = 32'h0;
    bit          frozen = 0;
    bit          misalign_exp = 0;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Instruction memory: random request acceptance, in-order responses
    // at least one cycle after acceptance.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            bus.imem_req_ready = (int'($urandom_range(99)) < ready_pct);
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = instr_of(pend_q[0].addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    // Monitor and reference model: compare outputs against the expected
    // fetch stream, then apply this cycle's handshakes to the model.
    always @(negedge clk) begin : mon
        bit   redir;
        bit   exp_valid;
        bit   exp_req;
        bit   done;
        int   occ;
        pend_t p;
        logic [31:0] tgt;
        if (rst_n) begin
            redir     = bus.redirect_valid;
            exp_valid = !redir && exp_q.size() > 0 && exp_q[0].filled;
            chk("if_valid", 32'(bus.if_valid), 32'(exp_valid));
            if (exp_valid && bus.if_valid) begin
                chk("if_pc", bus.if_pc, exp_q[0].pc);
                chk("if_instr", bus.if_instr, instr_of(exp_q[0].pc));
            end
            occ = exp_q.size();
            foreach (pend_q[i]) if (pend_q[i].epoch != epoch) occ++;
            exp_req = !redir && !frozen && occ < DEPTH;
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            if (exp_req && bus.imem_req_valid)
                chk("imem_addr", bus.imem_addr, model_pc);
            chk("misalign_exc", 32'(bus.fetch_misalign_exc), 32'(misalign_exp));
            chk("no_x", 32'($isunknown({bus.imem_req_valid, bus.imem_addr, bus.if_valid,
                bus.if_instr, bus.if_pc, bus.fetch_misalign_exc})), 32'(0));

            misalign_exp = 0;
            if (bus.imem_rsp_valid && pend_q.size() > 0) begin
                p = pend_q.pop_front();
                if (!redir && p.epoch == epoch) begin
                    done = 0;
                    foreach (exp_q[i]) begin
                        if (!done && !exp_q[i].filled) begin
                            exp_q[i].filled = 1;
                            done = 1;
                        end
                    end
                end
            end
            if (redir) begin
                exp_q.delete();
                epoch++;
                tgt = bus.redirect_pc;
`ifdef MIPS_FETCH_ALIGN_CHK_EN
                frozen       = (tgt[1:0] != 2'b00);
                misalign_exp = frozen;
                model_pc     = tgt;
`else
                model_pc = {tgt[31:2], 2'b00};
`endif
            end else begin
                if (bus.if_valid && bus.if_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    exp_q.push_back('{pc: model_pc, filled: 0});
                    p.epoch = epoch;
                    p.due   = cyc + 1 + int'($urandom_range(lat_extra));
                    p.addr  = bus.imem_addr;
                    pend_q.push_back(p);
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'(0));
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'(0));
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_misalign", 32'(bus.fetch_misalign_exc), 32'(0));

        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.if_ready = 1'b1;

        // Streaming with a single-cycle memory, then a redirect while a
        // response and a pop are both pending.
        step(20);
        redirect(32'h200);
        step(10);

        // Decode stall: queue fills to depth, then drains in order.
        bus.if_ready = 1'b0;
        step(10);
        bus.if_ready = 1'b1;
        step(15);

        // Redirect with several slow responses still in flight.
        lat_extra = 2;
        step(3);
        redirect(32'h100);
        step(15);
        lat_extra = 0;

        // PC wrap-around.
        redirect(32'hFFFF_FFF0);
        step(12);

        // Misaligned target followed by an aligned one.
        redirect(32'h102);
        step(5);
        redirect(32'h80);
        step(10);

        // Back-to-back redirects: the second target wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        step(1);
        bus.redirect_pc    = 32'h800;
        step(1);
        bus.redirect_valid = 1'b0;
        step(10);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                ready_pct = 40 + int'($urandom_range(60));
                lat_extra = int'($urandom_range(4));
            end
            bus.if_ready = ($urandom_range(3) != 0);
            if ($urandom_range(29) == 0) begin
                if ($urandom_range(7) == 0)
                    redirect($urandom);
                else if ($urandom_range(7) == 0)
                    redirect(32'hFFFF_FFE0 + 32'($urandom_range(7)) * 4);
                else
                    redirect($urandom & 32'hFFFF_FFFC);
            end else begin
                step(1);
            end
        end
        bus.if_ready = 1'b1;
        redirect(32'h40);
        step(20);

        chk("progress", 32'(pops > 200), 32'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
